// File: rtl/prog_counter_pkg.sv
// Shared types and constants for the programmable terminal counter.
//   state_e       : FSM state encoding (idle, running, finished)
//   DIR_*, MODE_* : encodings of the dir_up and auto_reload inputs
//   DEFAULT_WIDTH : default count width
package prog_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic DIR_DOWN     = 1'b0;
  localparam logic DIR_UP       = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle between a controller FSM and prog_counter.
//   load, load_val, dir_up, auto_reload, count_en : controller -> counter
//   count, busy, done, tc_pulse                    : counter -> controller
// master: the controller side; slave: the counter side.
interface prog_counter_if
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             dir_up;
  logic             auto_reload;
  logic             count_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc_pulse;

  modport master (
    output load, load_val, dir_up, auto_reload, count_en,
    input  count, busy, done, tc_pulse
  );

  modport slave (
    input  load, load_val, dir_up, auto_reload, count_en,
    output count, busy, done, tc_pulse
  );

endinterface

// File: rtl/prog_counter_prescaler.sv
// Divides the count enable so that only every PRESCALE-th enabled cycle produces a tick.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the division (a new run is being loaded)
//   en           : enable; the divider holds while low
//   tick         : single-cycle advance strobe (combinational from en)
module prog_counter_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastVal = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign tick = en && (cnt_q == LastVal);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable terminal counter: loads a terminal value and counts down to 0 or up to it,
// either once (done held until the next load) or periodically (auto-reload).
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : load/load_val/dir_up/auto_reload/count_en in;
//                  count/busy/done/tc_pulse out (all registered)
// Optional build macro PROG_COUNTER_PRESCALE_EN adds parameter PRESCALE: the count then
// advances only on every PRESCALE-th enabled cycle.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef PROG_COUNTER_PRESCALE_EN
  ,
  parameter int unsigned PRESCALE = 4
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  prog_counter_if.slave      bus
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] count_d, count_q;
  logic [WIDTH-1:0] target_d, target_q;
  logic             dir_d, dir_q;
  logic             mode_d, mode_q;
  logic             tc_d, tc_q;
  logic             step;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] next_val;

`ifdef PROG_COUNTER_PRESCALE_EN
  prog_counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (bus.load),
    .en     (bus.count_en),
    .tick   (step)
  );
`else
  assign step = bus.count_en;
`endif

  assign term_val = (dir_q == DIR_UP) ? target_q : '0;
  assign next_val = (dir_q == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;

    if (bus.load) begin
      target_d = bus.load_val;
      dir_d    = bus.dir_up;
      mode_d   = bus.auto_reload;
      if (bus.load_val == '0) begin
        // Zero-length run: finish immediately in either mode.
        state_d = StDone;
        count_d = '0;
        tc_d    = 1'b1;
      end else begin
        state_d = StRun;
        count_d = (bus.dir_up == DIR_UP) ? '0 : bus.load_val;
      end
    end else if (state_q == StRun && step) begin
      if (count_q == term_val) begin
        // Only reachable in auto-reload: terminal value was shown last step, restart.
        count_d = (dir_q == DIR_UP) ? '0 : target_q;
      end else begin
        count_d = next_val;
        if (next_val == term_val) begin
          tc_d = 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            state_d = StDone;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      target_q <= '0;
      dir_q    <= DIR_DOWN;
      mode_q   <= MODE_ONESHOT;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.tc_pulse = tc_q;

endmodule
